pe_mac_accumulator: RTL and testbench
=====================================

// Module: pe_mac_accumulator
//
// PURPOSE
//   Downstream stage of booth_wallace_multiplier_seq in the RISC-V PE datapath.
//   Consumes the signed 32-bit product stream (P/valid) and sums products into a wide
//   accumulator, forming a dot-product "packet" that ends on a last-beat marker.
//   Presents the finished sum on a valid/ready result port with overflow status.
//
// PARAMETERS
//   PROD_W  32  width of the signed product input (multiplier P)
//   ACC_W   40  internal signed accumulator width (guard bits above PROD_W)
//   OUT_W   32  signed result width on res_data
//   CNT_W    8  beat-counter width; counter saturates at 2**CNT_W-1
//
// PORTS
//   clk         in   1        rising-edge clock, sole clock domain
//   rst         in   1        synchronous, active-high reset
//   prod_valid  in   1        product beat valid (driven by multiplier valid)
//   prod        in   PROD_W   signed product
//   prod_last   in   1        beat closes the current packet
//   prod_ready  out  1        accumulator can accept a beat this cycle
//   res_valid   out  1        packet result available
//   res_ready   in   1        consumer accepts result
//   res_data    out  OUT_W    signed packet sum (wrapped or clamped, see CONFIGURATION)
//   res_count   out  CNT_W    number of beats in the packet
//   res_ovf     out  1        sum overflowed ACC_W, or is not representable in OUT_W
//
// BEHAVIOUR
//   - One clock (clk); reset (rst) is synchronous, active-high. At reset: state=IDLE, acc=0,
//     cnt=0, ovf=0, prod_ready=0 during the reset cycle, res_valid=0, res_data=0,
//     res_count=0, res_ovf=0.
//   - FSM states:
//     - IDLE: no packet open; prod_ready=1.
//     - ACCUM: packet open; prod_ready=1.
//     - HOLD: result pending; prod_ready=0, res_valid=1.
//   - Beat accepted when prod_valid && prod_ready:
//     - IDLE: acc <= sext(prod), cnt <= 1.
//     - ACCUM: acc <= acc + sext(prod), cnt <= sat_inc(cnt).
//     - Any beat: ACC_W signed-add overflow sets sticky ovf. The first beat clears the old ovf.
//   - Transitions:
//     - Accepted beat with prod_last=0 -> ACCUM.
//     - Accepted beat with prod_last=1 -> HOLD; res_* registered from the post-add values.
//     - Latency: res_valid rises exactly 1 cycle after the last beat is accepted.
//   - HOLD: res_data, res_count and res_ovf stay stable until res_valid && res_ready.
//     On that handshake -> IDLE; res_valid=0 the next cycle.
//   - A beat offered during HOLD is not accepted (prod_ready=0). It is accepted in IDLE on the
//     cycle after the result handshake; no beat is dropped or duplicated.
//   - The result register holds its last value when res_valid=0. The bench checks data only
//     while res_valid=1.
//   - res_ovf = sticky ACC_W overflow OR (final acc outside the signed OUT_W range).
//   - rst mid-packet or during HOLD discards the partial sum. The next accepted beat starts a
//     fresh packet.
//   - prod_valid=0 in ACCUM: the packet stays open indefinitely; no timeout.
//
// CONFIGURATION
//   PE_ACC_SAT_EN
//     defined:   res_data = acc clamped to [-2**(OUT_W-1), 2**(OUT_W-1)-1]; a sticky ACC_W
//                overflow clamps toward the sign of the last true sum direction.
//     undefined: res_data = acc[OUT_W-1:0] (two's-complement wrap).
//     res_ovf is identical in both builds.
//
// STRUCTURE
//   - pe_mac_pkg: FSM state enum (IDLE/ACCUM/HOLD), default width localparams,
//     sign-extend helper function.
//   - One sub-module, pe_acc_clamp: combinational ACC_W->OUT_W narrowing plus the
//     range-check flag; it contains the `ifdef PE_ACC_SAT_EN.
//   - FSM, accumulator, counter and result register live in the top module.
//
// TESTING
//   1. Beats 7006652, -2000000, -12000000(last), res_ready=1
//      -> res_data=-6993348, res_count=3, res_ovf=0, 1 cycle after the last beat.
//   2. Beats 1073676289 x3, last on the third
//      -> res_ovf=1; with PE_ACC_SAT_EN res_data=32'h7FFFFFFF; without, res_data=-1073938429.
//   3. Single-beat packet prod=-5, last=1 -> res_data=-5, res_count=1. Hold res_ready=0
//      for 5 cycles -> res_valid=1, data stable, prod_ready=0 throughout.
//   4. 2 beats (100, 200) then rst for 1 cycle, then beat 5 (last)
//      -> res_data=5, res_count=1, res_ovf=0.
//   5. prod_valid=1 with prod=7 held through HOLD. Result handshake at cycle N
//      -> beat accepted at cycle N+1 in IDLE; the next packet sum starts at 7.
//   6. 300 beats of prod=1 (CNT_W=8), last on beat 300 -> res_count=255 (saturated), res_data=300.

Source files
------------

// File: rtl/pe_mac_pkg.sv
// Shared types, default widths and the sign-extension helper for the PE MAC accumulator.
package pe_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int OUT_W_DEF  = 32;
    localparam int CNT_W_DEF  = 8;

    // Sign-extends the low w bits of v to 64 bits (w must be 1..64).
    function automatic logic signed [63:0] sext64(input logic [63:0] v, input int w);
        logic signed [63:0] shifted;
        shifted = signed'(v << (64 - w));
        return shifted >>> (64 - w);
    endfunction

endpackage

// File: rtl/pe_acc_clamp.sv
// Narrows the wide accumulator to the result width and flags sums outside that width.
// Saturating narrowing is selected by defining PE_ACC_SAT_EN; otherwise the result wraps.
module pe_acc_clamp
    import pe_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic             acc_ovf,
    input  logic             ovf_pos,
    output logic [OUT_W-1:0] data,
    output logic             out_of_range
);

    // In range only when every bit from the result sign bit upward matches.
    logic [ACC_W-OUT_W:0] upper_bits;
    assign upper_bits   = acc[ACC_W-1:OUT_W-1];
    assign out_of_range = !((&upper_bits) || !(|upper_bits));

`ifdef PE_ACC_SAT_EN
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    always_comb begin
        data = acc[OUT_W-1:0];
        if (acc_ovf) begin
            data = ovf_pos ? OUT_MAX : OUT_MIN;
        end else if (out_of_range) begin
            data = acc[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end
    end
`else
    logic unused_ovf_info;
    assign unused_ovf_info = acc_ovf ^ ovf_pos;
    assign data            = acc[OUT_W-1:0];
`endif

endmodule

// File: rtl/pe_mac_accumulator.sv
// Sums a signed product stream into a wide accumulator and presents each packet sum
// on a valid/ready result port. Build option: PE_ACC_SAT_EN (saturating result).
module pe_mac_accumulator
    import pe_mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               ovf_pos_q, ovf_pos_d;
    logic               res_valid_q, res_valid_d;
    logic [OUT_W-1:0]   res_data_q, res_data_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               res_ovf_q, res_ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic               accept;
    logic [OUT_W-1:0]   clamp_data;
    logic               clamp_oor;

    assign prod_ext   = ACC_W'(sext64(64'(prod), PROD_W));
    assign sum        = acc_q + prod_ext;
    assign add_ovf    = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign prod_ready = (state_q != ST_HOLD) && !rst;
    assign accept     = prod_valid && prod_ready;

    // Narrowing sees the post-add values so the result register captures the final sum.
    pe_acc_clamp #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .acc          (acc_d),
        .acc_ovf      (ovf_d),
        .ovf_pos      (ovf_pos_d),
        .data         (clamp_data),
        .out_of_range (clamp_oor)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        ovf_pos_d   = ovf_pos_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (state_q == ST_IDLE) begin
                        acc_d     = prod_ext;
                        cnt_d     = CNT_W'(1);
                        ovf_d     = 1'b0;
                        ovf_pos_d = 1'b0;
                    end else begin
                        acc_d = sum;
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        if (add_ovf) begin
                            ovf_d     = 1'b1;
                            ovf_pos_d = !prod_ext[ACC_W-1];
                        end
                    end
                    if (prod_last) begin
                        state_d     = ST_HOLD;
                        res_valid_d = 1'b1;
                        res_data_d  = clamp_data;
                        res_count_d = cnt_d;
                        res_ovf_d   = ovf_d || clamp_oor;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ovf_pos_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ovf_pos_q   <= ovf_pos_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_pe_mac_accumulator.sv
// Directed bench for pe_mac_accumulator: packet-level reference model checked every cycle
// plus literal expectations for each scenario.
module tb_pe_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic [31:0] prod;
    logic        prod_last;
    logic        prod_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_count;
    logic        res_ovf;

    pe_mac_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count),
        .res_ovf    (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Packet-level model: plain integer sums, 40-bit wrap only when the guard bits overflow.
    localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 39);
    localparam longint OUT_MAX = 64'sd2147483647;
    localparam longint OUT_MIN = -64'sd2147483648;

    bit     m_open = 0, m_pending = 0, m_ovf = 0, m_pos = 0;
    longint m_sum = 0;
    int     m_n = 0;
    longint e_data = 0;
    int     e_count = 0;
    bit     e_ovf = 0;
    bit     model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_open = 0; m_pending = 0; m_ovf = 0; m_sum = 0; m_n = 0;
            e_data = 0; e_count = 0; e_ovf = 0;
            model_live = 1;
        end else if (m_pending) begin
            if (res_ready) m_pending = 0;
        end else if (prod_valid) begin
            longint p;
            longint t;
            p = longint'($signed(prod));
            if (!m_open) begin
                m_sum = p; m_n = 1; m_ovf = 0;
            end else begin
                t = m_sum + p;
                if (t > ACC_MAX) begin m_ovf = 1; m_pos = 1; t -= (64'sd1 <<< 40); end
                else if (t < ACC_MIN) begin m_ovf = 1; m_pos = 0; t += (64'sd1 <<< 40); end
                m_sum = t;
                m_n = m_n + 1;
            end
            m_open = 1;
            if (prod_last) begin
                bit oor;
                int wrapped;
                oor = (m_sum > OUT_MAX) || (m_sum < OUT_MIN);
                wrapped = int'(m_sum);
`ifdef PE_ACC_SAT_EN
                if (m_ovf) e_data = m_pos ? OUT_MAX : OUT_MIN;
                else if (oor) e_data = (m_sum > 0) ? OUT_MAX : OUT_MIN;
                else e_data = m_sum;
`else
                e_data = longint'(wrapped);
`endif
                e_count = (m_n > 255) ? 255 : m_n;
                e_ovf = m_ovf || oor;
                m_pending = 1;
                m_open = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_live) begin
            check("cyc_prod_ready", longint'(prod_ready), longint'(!rst && !m_pending));
            check("cyc_res_valid", longint'(res_valid), longint'(m_pending));
            if (m_pending) begin
                check("cyc_res_data", longint'($signed(res_data)), e_data);
                check("cyc_res_count", longint'(res_count), longint'(e_count));
                check("cyc_res_ovf", longint'(res_ovf), longint'(e_ovf));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] p, input logic l);
        prod_valid = v;
        prod = p;
        prod_last = l;
    endtask

    // Waits (bounded) at negedges for res_valid, then checks the result; cycles waited returned.
    task automatic expect_result(input string name, input longint d, input int c, input bit o,
                                 output int waited);
        waited = 0;
        while (!res_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_valid"}, longint'(res_valid), 1);
        check({name, "_data"}, longint'($signed(res_data)), d);
        check({name, "_count"}, longint'(res_count), longint'(c));
        check({name, "_ovf"}, longint'(res_ovf), longint'(o));
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        res_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_prod_ready", longint'(prod_ready), 0);
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_res_data", longint'(res_data), 0);
        check("rst_res_count", longint'(res_count), 0);
        check("rst_res_ovf", longint'(res_ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: three-beat packet, consumer ready, one-cycle latency
        drive(1'b1, 32'sd7006652, 1'b0);    @(negedge clk);
        drive(1'b1, -32'sd2000000, 1'b0);   @(negedge clk);
        drive(1'b1, -32'sd12000000, 1'b1);  res_ready = 1'b1; @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        expect_result("t1", -64'sd6993348, 3, 1'b0, w);
        check("t1_latency", longint'(w), 0);
        release_result();

        // 2: out of 32-bit range
        repeat (2) begin drive(1'b1, 32'd1073676289, 1'b0); @(negedge clk); end
        drive(1'b1, 32'd1073676289, 1'b1); @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
`ifdef PE_ACC_SAT_EN
        expect_result("t2", 64'sd2147483647, 3, 1'b1, w);
`else
        expect_result("t2", -64'sd1073938429, 3, 1'b1, w);
`endif
        release_result();

        // 3: single beat, consumer stalls for 5 cycles
        drive(1'b1, -32'sd5, 1'b1); @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", longint'(res_valid), 1);
            check("t3_hold_data", longint'($signed(res_data)), -5);
            check("t3_hold_ready", longint'(prod_ready), 0);
            @(negedge clk);
        end
        expect_result("t3", -64'sd5, 1, 1'b0, w);
        release_result();

        // 4: reset discards a partial packet
        drive(1'b1, 32'd100, 1'b0); @(negedge clk);
        drive(1'b1, 32'd200, 1'b0); @(negedge clk);
        drive(1'b0, 32'd0, 1'b0); rst = 1'b1; @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'd5, 1'b1); @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        expect_result("t4", 64'sd5, 1, 1'b0, w);
        release_result();

        // 5: beat held through HOLD is taken exactly once after the handshake
        drive(1'b1, 32'd10, 1'b1); @(negedge clk);
        drive(1'b1, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        expect_result("t5a", 64'sd10, 1, 1'b0, w);
        res_ready = 1'b1; @(negedge clk);
        res_ready = 1'b0; @(negedge clk);
        drive(1'b1, 32'd3, 1'b1); @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        expect_result("t5b", 64'sd10, 2, 1'b0, w);
        release_result();

        // 6: beat counter saturation
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 32'd1, (i == 300)); @(negedge clk);
        end
        drive(1'b0, 32'd0, 1'b0);
        expect_result("t6", 64'sd300, 255, 1'b0, w);
        release_result();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
